// File: rtl/led_pat_pkg.sv
// Shared definitions for the LED pattern generator and decoder: pattern IDs,
// the canonical step rule for each pattern, and small mask helpers.
package led_pat_pkg;

  localparam int NUM_PATS = 8;

  localparam logic [2:0] PAT_WALK_L = 3'd0;
  localparam logic [2:0] PAT_WALK_R = 3'd1;
  localparam logic [2:0] PAT_BOUNCE = 3'd2;
  localparam logic [2:0] PAT_BLINK  = 3'd3;
  localparam logic [2:0] PAT_ALT    = 3'd4;
  localparam logic [2:0] PAT_FILL   = 3'd5;
  localparam logic [2:0] PAT_COUNT  = 3'd6;
  localparam logic [2:0] PAT_CENTER = 3'd7;

  typedef logic [7:0]          led_t;
  typedef logic [NUM_PATS-1:0] pat_mask_t;

  function automatic logic led_is_onehot(input led_t v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  // True when prev -> next is a legal single step of pattern id.
  function automatic logic pat_step_ok(input logic [2:0] id, input led_t prev, input led_t next);
    logic ok;
    ok = 1'b0;
    case (id)
      PAT_WALK_L: ok = (next == {prev[6:0], prev[7]});
      PAT_WALK_R: ok = (next == {prev[0], prev[7:1]});
      PAT_BOUNCE: ok = led_is_onehot(prev) && (next != 8'h00) &&
                       ((next == (prev << 1)) || (next == (prev >> 1)));
      PAT_BLINK:  ok = ((prev == 8'h00) && (next == 8'hFF)) ||
                       ((prev == 8'hFF) && (next == 8'h00));
      PAT_ALT:    ok = ((prev == 8'h55) && (next == 8'hAA)) ||
                       ((prev == 8'hAA) && (next == 8'h55));
      PAT_FILL:   ok = (prev == 8'hFF) ? (next == 8'h00) : (next == ((prev << 1) | 8'h01));
      PAT_COUNT:  ok = (next == (prev + 8'h01));
      PAT_CENTER: begin
        case (prev)
          8'h18:   ok = (next == 8'h24);
          8'h24:   ok = (next == 8'h42);
          8'h42:   ok = (next == 8'h81);
          8'h81:   ok = (next == 8'h18);
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Generator side: first frame of each pattern.
  function automatic led_t pat_seed(input logic [2:0] id);
    led_t v;
    case (id)
      PAT_WALK_L, PAT_BOUNCE: v = 8'h01;
      PAT_WALK_R:             v = 8'h80;
      PAT_ALT:                v = 8'h55;
      PAT_CENTER:             v = 8'h18;
      default:                v = 8'h00;
    endcase
    return v;
  endfunction

  // Generator side: next frame; up selects BOUNCE direction (caller flips it at the ends).
  function automatic led_t pat_next(input logic [2:0] id, input led_t cur, input logic up);
    led_t v;
    case (id)
      PAT_WALK_L: v = {cur[6:0], cur[7]};
      PAT_WALK_R: v = {cur[0], cur[7:1]};
      PAT_BOUNCE: v = up ? (cur << 1) : (cur >> 1);
      PAT_BLINK:  v = (cur == 8'h00) ? 8'hFF : 8'h00;
      PAT_ALT:    v = (cur == 8'h55) ? 8'hAA : 8'h55;
      PAT_FILL:   v = (cur == 8'hFF) ? 8'h00 : ((cur << 1) | 8'h01);
      PAT_COUNT:  v = cur + 8'h01;
      default: begin
        case (cur)
          8'h18:   v = 8'h24;
          8'h24:   v = 8'h42;
          8'h42:   v = 8'h81;
          default: v = 8'h18;
        endcase
      end
    endcase
    return v;
  endfunction

  function automatic logic mask_is_onehot(input pat_mask_t m);
    return (m != '0) && ((m & (m - pat_mask_t'(1))) == '0);
  endfunction

  function automatic logic [2:0] mask_to_id(input pat_mask_t m);
    logic [2:0] id;
    id = 3'd0;
    for (int i = 0; i < NUM_PATS; i++) begin
      if (m[i]) id = 3'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/led_step_matcher.sv
// Combinational classifier: which canonical patterns accept the transition prev -> next.
module led_step_matcher
  import led_pat_pkg::*;
(
  input  logic [7:0]          prev,
  input  logic [7:0]          next,
  output logic [NUM_PATS-1:0] match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PATS; i++) begin
      match[i] = pat_step_ok(3'(i), prev, next);
    end
  end

endmodule

// File: rtl/led_pattern_decoder.sv
// Watches an 8-bit LED bus, narrows the playing pattern down by elimination,
// measures the step interval and flags a stalled stream.
module led_pattern_decoder
  import led_pat_pkg::*;
#(
  parameter int               CNT_W        = 24,
  parameter int               LOCK_STEPS   = 9,
  parameter logic [CNT_W-1:0] FAST_THRESH  = CNT_W'(2_000_000),
  parameter logic [CNT_W-1:0] PAUSE_CYCLES = CNT_W'(12_000_000)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] led_in,
  output logic [2:0] pat_id,
  output logic       locked,
  output logic       speed_fast,
  output logic       paused,
  output logic       step_pulse,
  output logic       mismatch_pulse
);

  localparam int               RUN_W  = $clog2(LOCK_STEPS + 1);
  localparam logic [RUN_W-1:0] LOCK_N = RUN_W'(LOCK_STEPS);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  logic [7:0]       prev_q;
  pat_mask_t        cand_p1;
  logic [RUN_W-1:0] run_cnt_p1;
  logic [CNT_W-1:0] intv_p1;
  logic             intv_vld_p1;

  logic             step_p0;
  pat_mask_t        match_p0;
  pat_mask_t        cand_nxt_p0;
  logic [RUN_W-1:0] run_nxt_p0;
  logic             lock_nxt_p0;
  logic [CNT_W-1:0] intv_inc_p0;

  // ---- p0: step detection and candidate narrowing (combinational) ----
  assign step_p0 = ena && (led_in != prev_q);

  led_step_matcher u_matcher (
    .prev  (prev_q),
    .next  (led_in),
    .match (match_p0)
  );

  always_comb begin
    cand_nxt_p0 = match_p0;
    run_nxt_p0  = RUN_W'(1);
    if ((cand_p1 & match_p0) != '0) begin
      cand_nxt_p0 = cand_p1 & match_p0;
      run_nxt_p0  = sat_inc_run(run_cnt_p1);
    end
  end

  assign lock_nxt_p0 = mask_is_onehot(cand_nxt_p0) && (run_nxt_p0 >= LOCK_N);
  assign intv_inc_p0 = sat_inc_cnt(intv_p1);

  // ---- p1: state and output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q         <= 8'h00;
      cand_p1        <= '0;
      run_cnt_p1     <= '0;
      intv_p1        <= '0;
      intv_vld_p1    <= 1'b0;
      pat_id         <= 3'd0;
      locked         <= 1'b0;
      speed_fast     <= 1'b0;
      paused         <= 1'b0;
      step_pulse     <= 1'b0;
      mismatch_pulse <= 1'b0;
    end else if (ena) begin
      prev_q         <= led_in;
      step_pulse     <= step_p0;
      mismatch_pulse <= step_p0 && (match_p0 == '0);
      if (step_p0) begin
        // A step always beats a simultaneous pause timeout.
        cand_p1     <= cand_nxt_p0;
        run_cnt_p1  <= run_nxt_p0;
        intv_p1     <= '0;
        intv_vld_p1 <= 1'b1;
        paused      <= 1'b0;
        if (intv_vld_p1) speed_fast <= (intv_p1 < FAST_THRESH);
        locked <= lock_nxt_p0;
        if (lock_nxt_p0) pat_id <= mask_to_id(cand_nxt_p0);
      end else begin
        intv_p1 <= intv_inc_p0;
        // The interval spanning a pause is meaningless, so the next step must not grade speed.
        if (intv_inc_p0 >= PAUSE_CYCLES) begin
          paused      <= 1'b1;
          intv_vld_p1 <= 1'b0;
        end
      end
    end else begin
      step_pulse     <= 1'b0;
      mismatch_pulse <= 1'b0;
    end
  end

endmodule
